student_fifo8: RTL and testbench
================================

STUDENT_FIFO8 -- requirements
Module: student_fifo8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of storage entries, a power of two >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous clear of all stored entries.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: write word from the upstream producer.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the FIFO accepts a word this cycle.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the oldest stored word, first-word-fall-through.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes out_data this cycle.
REQ-012 The block SHALL have port count, output, log2(DEPTH)+1 bits: number of occupied entries, 0..DEPTH.

Function
REQ-013 Storage SHALL be DEPTH entries of WIDTH-bit registers, each written only when selected by the write pointer and a push occurs; unselected entries hold their value.
REQ-014 A push SHALL occur on a rising edge when in_valid=1 and in_ready=1: in_data is written at wr_ptr and wr_ptr increments.
REQ-015 A pop SHALL occur on a rising edge when out_valid=1 and out_ready=1: rd_ptr increments.
REQ-016 wr_ptr and rd_ptr SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no other effect.
REQ-017 in_ready SHALL equal (count < DEPTH), driven combinationally from registered state only, never from in_valid or out_ready.
REQ-018 out_valid SHALL equal (count != 0), driven combinationally from registered state only.
REQ-019 out_data SHALL equal the entry at rd_ptr when out_valid=1, and SHALL be all zeros when out_valid=0.
REQ-020 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N when the FIFO was empty; zero-cycle bypass from in_data to out_data is forbidden.
REQ-021 count SHALL update on each edge: +1 for push only, -1 for pop only, unchanged for push and pop together or for neither.
REQ-022 Full (count=DEPTH): in_ready=0; no push occurs even if a pop occurs on the same edge; a pop decrements count.
REQ-023 Empty (count=0): out_valid=0; no pop occurs regardless of out_ready; a push increments count.
REQ-024 Simultaneous push and pop with 0<count<DEPTH SHALL write at wr_ptr, advance both pointers, and leave count unchanged.
REQ-025 flush=1 on an edge SHALL set wr_ptr, rd_ptr and count to 0 and discard any push or pop on that edge; storage contents need not be cleared.
REQ-026 Order SHALL be strict first-in-first-out; no word SHALL be duplicated, lost or reordered except by flush or reset.

Reset
REQ-027 While reset=1, regardless of clk: wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1, out_data=0.
REQ-028 Storage registers SHALL NOT need reset; their contents SHALL never be visible because out_data is forced to zero while empty.
REQ-029 Reset asserted mid-operation SHALL abandon all stored words immediately; the first edge after deassertion SHALL behave as operation on an empty FIFO.

Verification
REQ-030 Fill then drain: push 16'h0001..16'h0008 with out_ready=0 -> count=8, in_ready=0; then out_ready=1 for 8 cycles -> out_data 0001..0008 in order, then count=0, out_valid=0, out_data=0000.
REQ-031 Push on full: with count=8, hold in_valid=1, in_data=16'hDEAD, out_ready=0 for 3 cycles -> count stays 8, 16'hDEAD never appears on out_data.
REQ-032 Full with simultaneous pop: count=8, in_valid=1, out_ready=1 for one edge -> count=7, head word popped, offered word not written.
REQ-033 Wrap-around streaming: in_valid=1 and out_ready=1 continuously for 20 words 16'h0100..16'h0113 after one prefill word -> count stays 1 after the prefill edge, output order exact across pointer wrap.
REQ-034 Flush with push: count=5, flush=1, in_valid=1, in_data=16'hBEEF on one edge -> count=0, out_valid=0; next push of 16'h1234 -> out_data=16'h1234.
REQ-035 Async reset mid-stream: count=3, assert reset between clock edges -> count=0, out_valid=0, in_ready=1, out_data=0 before the next edge.

Source files
------------

// File: rtl/student_fifo8.sv
// student_fifo8: first-word-fall-through FIFO with a valid/ready handshake
// on both sides. Storage is a bank of plain registers without reset.
// out_data is forced to zero whenever the FIFO is empty, so stale storage
// contents are never visible. The occupancy counter is one bit wider than
// the pointers, which lets it tell a full FIFO from an empty one.
module student_fifo8 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             push, pop;
  logic [WIDTH-1:0] mem [DEPTH];

  // Handshake flags come from registered occupancy only, so neither ready
  // nor valid can combinationally depend on the other side's inputs.
  assign in_ready  = (count_reg < FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  // A flush on the same edge cancels any transfer the handshakes would
  // otherwise have made.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Head word falls through; it is zeroed while empty so that storage
  // never leaks out.
  assign out_data = out_valid ? mem[rd_ptr_reg] : '0;

  // Storage entries: each register loads only when the write pointer
  // selects it on a push.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      // Capture the producer word into this entry when it is the push target
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= in_data;
        end
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  // Next pointer and occupancy values from flush, push and pop
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap naturally.
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: tb/tb_student_fifo8.sv
// Testbench for student_fifo8: directed scenarios followed by random
// traffic. Every cycle is compared against a queue-based FIFO model.
module tb_student_fifo8;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;

  int checks;
  int failures;
  logic [15:0] q[$];

  student_fifo8 #(.WIDTH(16), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model's current occupancy and head word
  task automatic check_outputs(input string tag);
    logic [15:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : 16'h0000;
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(q.size() < 8));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, "_out_data"}, 32'(out_data), 32'(exp_data));
    $display("%0t %s iv=%0b id=%h ordy=%0b fl=%0b -> cnt=%0d od=%h ov=%0b ir=%0b",
             $time, tag, in_valid, in_data, out_ready, flush, count, out_data, out_valid, in_ready);
  endtask

  // Drive one cycle of inputs, check outputs before the edge, then advance the model.
  task automatic cycle(input string tag, input logic iv, input logic [15:0] id,
                       input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs(tag);
    if (fl) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && ordy;
      do_push = iv && (q.size() < 8);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_data   = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset held across edges, even with inputs active
    in_valid  = 1'b1;
    in_data   = 16'h5555;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;

    // Fill then drain
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 16'(i), 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd8);
    check("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
    check("drained_count", 32'(count), 32'd0);
    check("drained_out_valid", 32'(out_valid), 32'd0);
    check("drained_out_data", 32'(out_data), 32'd0);
    cycle("empty_pop", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Push on full, then full with simultaneous pop
    for (int i = 0; i < 8; i++) cycle("refill", 1'b1, 16'h0010 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("push_full", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    cycle("full_pop", 1'b1, 16'hCAFE, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 32'd7);
    check("full_pop_head", 32'(out_data), 32'h0011);
    for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Wrap-around streaming after one prefill word
    cycle("prefill", 1'b1, 16'h00FF, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
    check("stream_count", 32'(count), 32'd1);
    check("stream_tail", 32'(out_data), 32'h0113);
    cycle("stream_end", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush with push on the same edge
    for (int i = 0; i < 5; i++) cycle("pre_flush", 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    cycle("flush", 1'b1, 16'hBEEF, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    cycle("post_flush", 1'b1, 16'h1234, 1'b0, 1'b0);
    check("post_flush_data", 32'(out_data), 32'h1234);
    cycle("post_flush_pop", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) cycle("pre_reset", 1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    q.delete();
    check("areset_count", 32'(count), 32'd0);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_in_ready", 32'(in_ready), 32'd1);
    check("areset_out_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cycle("after_reset", 1'b1, 16'h0400, 1'b0, 1'b0);
    cycle("after_reset_pop", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic with phases biased toward filling or draining
    for (int phase = 0; phase < 8; phase++) begin
      int pin, pout;
      pin  = (phase % 2 == 0) ? 80 : 30;
      pout = (phase % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 50; i++) begin
        cycle("rand",
              ($urandom_range(99) < pin),
              16'($urandom()),
              ($urandom_range(99) < pout),
              ($urandom_range(39) == 0));
      end
    end
    check_outputs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
